hdmi_tmds_encoder: RTL and testbench

HDMI_TMDS_ENCODER -- requirements
Module: hdmi_tmds_encoder

---
 rtl/hdmi_tmds_encoder.sv | 225 ++++++++++++++++++++++
 tb/tb_hdmi_tmds_encoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_tmds_encoder.sv
// Multi-lane HDMI TMDS encoder: 8b/10b video coding with per-lane running disparity,
// control tokens, TERC4 data-island symbols and guard bands, four-edge fixed latency.
module hdmi_tmds_encoder #(
    parameter int          NUM_CH   = 3,
    parameter logic [29:0] GB_VIDEO = {10'b1011001100, 10'b0100110011, 10'b1011001100}
) (
    input  logic                  pix_clk,
    input  logic                  rstn,
    input  logic [2:0]            mode,
    input  logic [8*NUM_CH-1:0]   din,
    input  logic [2*NUM_CH-1:0]   ctrl,
    input  logic [4*NUM_CH-1:0]   terc4,
    output logic [10*NUM_CH-1:0]  dout
);

    typedef enum logic [2:0] {
        M_CTRL      = 3'd0,
        M_VIDEO     = 3'd1,
        M_VIDEO_GB  = 3'd2,
        M_ISLAND    = 3'd3,
        M_ISLAND_GB = 3'd4
    } mode_t;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] ISLAND_GB_SYM = 10'b0100110011;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = 10'b1101010100;
            2'b01:   s = 10'b0010101011;
            2'b10:   s = 10'b0101010100;
            default: s = 10'b1010101011;
        endcase
        return s;
    endfunction

    function automatic logic [9:0] terc4_sym(input logic [3:0] t);
        logic [9:0] s;
        case (t)
            4'd0:    s = 10'b1010011100;
            4'd1:    s = 10'b1001100011;
            4'd2:    s = 10'b1011100100;
            4'd3:    s = 10'b1011100010;
            4'd4:    s = 10'b0101110001;
            4'd5:    s = 10'b0100011110;
            4'd6:    s = 10'b0110001110;
            4'd7:    s = 10'b0100111100;
            4'd8:    s = 10'b1011001100;
            4'd9:    s = 10'b0100111001;
            4'd10:   s = 10'b0110011100;
            4'd11:   s = 10'b1011000110;
            4'd12:   s = 10'b1010001110;
            4'd13:   s = 10'b1001110001;
            4'd14:   s = 10'b0101100011;
            default: s = 10'b1011000011;
        endcase
        return s;
    endfunction

    // Mode travels with the data; reserved codes are folded to CTRL on entry.
    mode_t s1_mode_reg, s2_mode_reg, s3_mode_reg;

    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            s1_mode_reg <= M_CTRL;
            s2_mode_reg <= M_CTRL;
            s3_mode_reg <= M_CTRL;
        end else begin
            s1_mode_reg <= (mode > 3'd4) ? M_CTRL : mode_t'(mode);
            s2_mode_reg <= s1_mode_reg;
            s3_mode_reg <= s2_mode_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
            logic [7:0]        s1_din_reg;
            logic [1:0]        s1_ctrl_reg;
            logic [3:0]        s1_terc4_reg;
            logic [3:0]        s1_n1_reg;
            logic [8:0]        s2_qm_reg;
            logic [3:0]        s2_n1_reg;
            logic [3:0]        s2_n0_reg;
            logic [1:0]        s2_ctrl_reg;
            logic [3:0]        s2_terc4_reg;
            logic [8:0]        s3_qm_reg;
            logic [3:0]        s3_n1_reg;
            logic [3:0]        s3_n0_reg;
            logic [9:0]        s3_sym_reg;
            logic [9:0]        dout_reg;
            logic signed [4:0] cnt_reg;

            logic [8:0]        qm_next;
            logic              decision;
            logic [9:0]        sym_next;
            logic [9:0]        enc_next;
            logic signed [4:0] cnt_next;
            logic signed [4:0] diff;
            logic signed [4:0] two_q8;
            logic signed [4:0] two_nq8;
            logic [9:0]        gb_word;

            // Lanes beyond the third reuse guard-band word 0.
            if (gi < 3) begin : g_gb
                assign gb_word = GB_VIDEO[10*gi +: 10];
            end else begin : g_gb_wrap
                assign gb_word = GB_VIDEO[9:0];
            end

            always_ff @(posedge pix_clk or negedge rstn) begin
                if (!rstn) begin
                    s1_din_reg   <= '0;
                    s1_ctrl_reg  <= '0;
                    s1_terc4_reg <= '0;
                    s1_n1_reg    <= '0;
                end else begin
                    s1_din_reg   <= din[8*gi +: 8];
                    s1_ctrl_reg  <= ctrl[2*gi +: 2];
                    s1_terc4_reg <= terc4[4*gi +: 4];
                    s1_n1_reg    <= ones8(din[8*gi +: 8]);
                end
            end

            // Transition-minimising stage: XNOR chain when the byte is ones-heavy.
            always_comb begin
                decision = (s1_n1_reg > 4'd4) || ((s1_n1_reg == 4'd4) && !s1_din_reg[0]);
                qm_next    = '0;
                qm_next[0] = s1_din_reg[0];
                for (int i = 1; i < 8; i++) begin
                    qm_next[i] = decision ? ~(qm_next[i-1] ^ s1_din_reg[i])
                                          :  (qm_next[i-1] ^ s1_din_reg[i]);
                end
                qm_next[8] = ~decision;
            end

            always_ff @(posedge pix_clk or negedge rstn) begin
                if (!rstn) begin
                    s2_qm_reg    <= '0;
                    s2_n1_reg    <= '0;
                    s2_n0_reg    <= '0;
                    s2_ctrl_reg  <= '0;
                    s2_terc4_reg <= '0;
                end else begin
                    s2_qm_reg    <= qm_next;
                    s2_n1_reg    <= ones8(qm_next[7:0]);
                    s2_n0_reg    <= 4'd8 - ones8(qm_next[7:0]);
                    s2_ctrl_reg  <= s1_ctrl_reg;
                    s2_terc4_reg <= s1_terc4_reg;
                end
            end

            // Non-video symbols are resolved one stage early so the last stage only muxes.
            always_comb begin
                sym_next = ctrl_sym(s2_ctrl_reg);
                case (s2_mode_reg)
                    M_VIDEO_GB:  sym_next = gb_word;
                    M_ISLAND:    sym_next = terc4_sym(s2_terc4_reg);
                    M_ISLAND_GB: sym_next = (gi == 0) ? terc4_sym(s2_terc4_reg) : ISLAND_GB_SYM;
                    default:     sym_next = ctrl_sym(s2_ctrl_reg);
                endcase
            end

            always_ff @(posedge pix_clk or negedge rstn) begin
                if (!rstn) begin
                    s3_qm_reg  <= '0;
                    s3_n1_reg  <= '0;
                    s3_n0_reg  <= '0;
                    s3_sym_reg <= CTRL_TOKEN_00;
                end else begin
                    s3_qm_reg  <= s2_qm_reg;
                    s3_n1_reg  <= s2_n1_reg;
                    s3_n0_reg  <= s2_n0_reg;
                    s3_sym_reg <= sym_next;
                end
            end

            // DC-balancing stage; the sign test looks only at cnt[4] once cnt == 0 is excluded.
            always_comb begin
                diff     = $signed({1'b0, s3_n1_reg}) - $signed({1'b0, s3_n0_reg});
                two_q8   = $signed({3'b000, s3_qm_reg[8], 1'b0});
                two_nq8  = $signed({3'b000, ~s3_qm_reg[8], 1'b0});
                enc_next = s3_sym_reg;
                cnt_next = '0;
                if (s3_mode_reg == M_VIDEO) begin
                    if ((cnt_reg == 5'sd0) || (s3_n1_reg == s3_n0_reg)) begin
                        enc_next = {~s3_qm_reg[8], s3_qm_reg[8],
                                    s3_qm_reg[8] ? s3_qm_reg[7:0] : ~s3_qm_reg[7:0]};
                        cnt_next = s3_qm_reg[8] ? (cnt_reg + diff) : (cnt_reg - diff);
                    end else if ((!cnt_reg[4] && (s3_n1_reg > s3_n0_reg)) ||
                                 ( cnt_reg[4] && (s3_n0_reg > s3_n1_reg))) begin
                        enc_next = {1'b1, s3_qm_reg[8], ~s3_qm_reg[7:0]};
                        cnt_next = cnt_reg + two_q8 - diff;
                    end else begin
                        enc_next = {1'b0, s3_qm_reg[8], s3_qm_reg[7:0]};
                        cnt_next = cnt_reg + diff - two_nq8;
                    end
                end
            end

            always_ff @(posedge pix_clk or negedge rstn) begin
                if (!rstn) begin
                    dout_reg <= '0;
                    cnt_reg  <= '0;
                end else begin
                    dout_reg <= enc_next;
                    cnt_reg  <= cnt_next;
                end
            end

            assign dout[10*gi +: 10] = dout_reg;
        end
    endgenerate

endmodule

// File: tb/tb_hdmi_tmds_encoder.sv
// Randomised and directed bench for hdmi_tmds_encoder (4 lanes) against a
// disparity-tracking reference model; expected symbols are queued with fixed latency.
module tb_hdmi_tmds_encoder;

    localparam int NCH = 4;

    logic          pix_clk = 1'b0;
    logic          rstn    = 1'b0;
    logic [2:0]    mode    = '0;
    logic [31:0]   din     = '0;
    logic [7:0]    ctrl    = '0;
    logic [15:0]   terc4   = '0;
    logic [39:0]   dout;

    always #5 pix_clk = ~pix_clk;

    hdmi_tmds_encoder #(.NUM_CH(NCH)) dut (
        .pix_clk (pix_clk),
        .rstn    (rstn),
        .mode    (mode),
        .din     (din),
        .ctrl    (ctrl),
        .terc4   (terc4),
        .dout    (dout)
    );

    logic [9:0] terc4_tab [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    logic [9:0] ctrl_tab [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
    logic [9:0] gb_tab [3]   = '{10'b1011001100, 10'b0100110011, 10'b1011001100};

    typedef struct {
        logic [39:0] sym;
        bit          video;
    } exp_t;

    exp_t        exp_q[$];
    logic [39:0] obs_q[$];
    int          cnt_m  [NCH];
    int          rd_obs [NCH];
    int          rd_max [NCH];
    int          tests = 0;
    int          fails = 0;

    task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    // Reference: choose the inversion that steers the running ones-minus-zeros
    // of the emitted words toward zero; that running value is the disparity.
    function automatic logic [9:0] model_lane(input int k, input logic [2:0] m, input logic [7:0] d,
                                              input logic [1:0] c, input logic [3:0] t);
        logic [8:0] q;
        logic [9:0] w;
        int         n1;
        int         m1;
        bit         dec;
        bit         inv;
        if (m == 3'd1) begin
            n1   = $countones(d);
            dec  = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
            q    = '0;
            q[0] = d[0];
            for (int i = 1; i < 8; i++) q[i] = dec ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
            q[8] = !dec;
            m1   = $countones(q[7:0]);
            if (cnt_m[k] == 0 || m1 == 4) inv = !q[8];
            else                          inv = ((cnt_m[k] > 0) == (m1 > 4));
            w = {inv, q[8], inv ? ~q[7:0] : q[7:0]};
            cnt_m[k] += 2 * $countones(w) - 10;
        end else begin
            case (m)
                3'd2:    w = (k < 3) ? gb_tab[k] : gb_tab[0];
                3'd3:    w = terc4_tab[t];
                3'd4:    w = (k == 0) ? terc4_tab[t] : 10'b0100110011;
                default: w = ctrl_tab[c];
            endcase
            cnt_m[k] = 0;
        end
        return w;
    endfunction

    task automatic reset_model();
        exp_t e;
        exp_q.delete();
        e.sym   = {4{10'b1101010100}};
        e.video = 1'b0;
        for (int i = 0; i < 3; i++) exp_q.push_back(e);
        for (int k = 0; k < NCH; k++) begin
            cnt_m[k]  = 0;
            rd_obs[k] = 0;
        end
    endtask

    task automatic step(input logic [2:0] m, input logic [31:0] d, input logic [7:0] c, input logic [15:0] t);
        exp_t e;
        exp_t o;
        int   a;
        mode    = m;
        din     = d;
        ctrl    = c;
        terc4   = t;
        e.video = (m == 3'd1);
        e.sym   = '0;
        for (int k = 0; k < NCH; k++)
            e.sym[10*k +: 10] = model_lane(k, m, d[8*k +: 8], c[2*k +: 2], t[4*k +: 4]);
        exp_q.push_back(e);
        @(posedge pix_clk);
        #1;
        o = exp_q.pop_front();
        obs_q.push_back(dout);
        for (int k = 0; k < NCH; k++) begin
            check_eq($sformatf("slot%0d ch%0d", obs_q.size() - 1, k),
                     {30'd0, dout[10*k +: 10]}, {30'd0, o.sym[10*k +: 10]});
            if (o.video) begin
                rd_obs[k] += 2 * $countones(dout[10*k +: 10]) - 10;
                a = (rd_obs[k] < 0) ? -rd_obs[k] : rd_obs[k];
                if (a > rd_max[k]) rd_max[k] = a;
            end else begin
                rd_obs[k] = 0;
            end
        end
    endtask

    function automatic logic [9:0] lane_of(input int idx, input int k);
        logic [39:0] w;
        w = obs_q[idx];
        return w[10*k +: 10];
    endfunction

    task automatic flush();
        repeat (3) step(3'd0, 32'd0, 8'd0, 16'd0);
    endtask

    initial begin
        int s;
        reset_model();
        repeat (2) @(posedge pix_clk);
        #1;
        check_eq("reset dout", dout, 40'd0);
        @(posedge pix_clk);
        #3 rstn = 1'b1;

        // Scenario 1: two zero bytes from cnt = 0
        step(3'd0, 32'd0, 8'd0, 16'd0);
        s = obs_q.size();
        step(3'd1, 32'd0, 8'd0, 16'd0);
        step(3'd1, 32'd0, 8'd0, 16'd0);
        flush();
        for (int k = 0; k < NCH; k++) begin
            check_eq($sformatf("s1 first ch%0d", k), {30'd0, lane_of(s + 3, k)}, {30'd0, 10'b0100000000});
            check_eq($sformatf("s1 second ch%0d", k), {30'd0, lane_of(s + 4, k)}, {30'd0, 10'b1111111111});
        end

        // Scenario 2: 0xFF, then CTRL 10, then a zero byte proves cnt was cleared
        s = obs_q.size();
        step(3'd1, 32'hFFFF_FFFF, 8'd0, 16'd0);
        step(3'd0, 32'd0, 8'hAA, 16'd0);
        step(3'd1, 32'd0, 8'd0, 16'd0);
        flush();
        for (int k = 0; k < NCH; k++) begin
            check_eq($sformatf("s2 ff ch%0d", k), {30'd0, lane_of(s + 3, k)}, {30'd0, 10'b1000000000});
            check_eq($sformatf("s2 ctrl ch%0d", k), {30'd0, lane_of(s + 4, k)}, {30'd0, 10'b0101010100});
            check_eq($sformatf("s2 restart ch%0d", k), {30'd0, lane_of(s + 5, k)}, {30'd0, 10'b0100000000});
        end

        // Scenario 3: TERC4 sweep
        s = obs_q.size();
        for (int n = 0; n < 16; n++) step(3'd3, 32'd0, 8'd0, {4{4'(n)}});
        flush();
        for (int n = 0; n < 16; n++)
            for (int k = 0; k < NCH; k++)
                check_eq($sformatf("s3 terc4 %0d ch%0d", n, k), {30'd0, lane_of(s + 3 + n, k)}, {30'd0, terc4_tab[n]});

        // Scenario 4: guard bands
        s = obs_q.size();
        step(3'd2, $urandom, 8'd0, 16'd0);
        step(3'd2, $urandom, 8'd0, 16'd0);
        step(3'd1, $urandom, 8'd0, 16'd0);
        step(3'd4, 32'd0, 8'd0, 16'hCCCC);
        flush();
        for (int j = 0; j < 2; j++) begin
            check_eq($sformatf("s4 vgb%0d ch0", j), {30'd0, lane_of(s + 3 + j, 0)}, {30'd0, 10'b1011001100});
            check_eq($sformatf("s4 vgb%0d ch1", j), {30'd0, lane_of(s + 3 + j, 1)}, {30'd0, 10'b0100110011});
            check_eq($sformatf("s4 vgb%0d ch2", j), {30'd0, lane_of(s + 3 + j, 2)}, {30'd0, 10'b1011001100});
            check_eq($sformatf("s4 vgb%0d ch3", j), {30'd0, lane_of(s + 3 + j, 3)}, {30'd0, 10'b1011001100});
        end
        check_eq("s4 igb ch0", {30'd0, lane_of(s + 6, 0)}, {30'd0, 10'b1010001110});
        for (int k = 1; k < NCH; k++)
            check_eq($sformatf("s4 igb ch%0d", k), {30'd0, lane_of(s + 6, k)}, {30'd0, 10'b0100110011});

        // Scenario 5: long random video run with DC bound
        for (int k = 0; k < NCH; k++) rd_max[k] = 0;
        for (int i = 0; i < 10000; i++) step(3'd1, $urandom, 8'd0, 16'd0);
        flush();
        for (int k = 0; k < NCH; k++)
            check_eq($sformatf("dc bound ch%0d max=%0d", k, rd_max[k]), {39'd0, (rd_max[k] <= 10)}, 40'd1);

        // Random mix of all modes, including reserved codes
        for (int i = 0; i < 1500; i++) begin
            logic [2:0] m;
            m = ($urandom_range(0, 1) == 1) ? 3'd1 : 3'($urandom_range(0, 7));
            step(m, $urandom, 8'($urandom), 16'($urandom));
        end

        // Scenario 6: asynchronous reset pulse mid-video
        for (int i = 0; i < 20; i++) step(3'd1, $urandom, 8'd0, 16'd0);
        #1 rstn = 1'b0;
        #1 check_eq("async reset dout", dout, 40'd0);
        reset_model();
        @(posedge pix_clk);
        #3 rstn = 1'b1;
        s = obs_q.size();
        step(3'd1, 32'd0, 8'd0, 16'd0);
        for (int i = 0; i < 30; i++) step(3'd1, $urandom, 8'd0, 16'd0);
        flush();
        for (int k = 0; k < NCH; k++) begin
            for (int j = 0; j < 3; j++)
                check_eq($sformatf("s6 token%0d ch%0d", j, k), {30'd0, lane_of(s + j, k)}, {30'd0, 10'b1101010100});
            check_eq($sformatf("s6 resume ch%0d", k), {30'd0, lane_of(s + 3, k)}, {30'd0, 10'b0100000000});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
